memory_arbiter: RTL and testbench

Round-robin arbiter that shares one port of the dual-port simulation memory between three requesters: instruction fetch, data access, and debug/loader. It serialises requests into single-access transactions on the memory's enable/ready handshake. It returns read data, with a one-cycle ready pulse, only to the granted requester. It sits between the core bus masters and the memory port in the simulation bench and in the SoC top.

---
 rtl/memory_arbiter.sv | 175 +++++++++++++++++
 tb/tb_memory_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin arbiter sharing one memory port between three masters (optional timeout: ARB_TIMEOUT_EN)
module memory_arbiter #(
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [3*MEM_ADDR_WIDTH-1:0] i_m_addr,
    input  logic [95:0]                 i_m_din,
    input  logic [11:0]                 i_m_wr,
    input  logic [2:0]                  i_m_enable,
    output logic [31:0]                 o_m_dout,
    output logic [2:0]                  o_m_ready,
    output logic [2:0]                  o_m_error,
    output logic [MEM_ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [31:0]                 o_mem_din,
    output logic [3:0]                  o_mem_wr,
    output logic                        o_mem_enable,
    input  logic [31:0]                 i_mem_dout,
    input  logic                        i_mem_ready,
    output logic                        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [1:0]                  r_grant;
    logic [1:0]                  r_last_grant;
    logic [1:0]                  w_cand1;
    logic [1:0]                  w_cand2;
    logic [1:0]                  w_winner;
    logic                        w_any_req;
    logic                        w_start;
    logic                        w_expire;
    logic                        w_timeout;
    logic [MEM_ADDR_WIDTH-1:0]   r_mem_addr;
    logic [31:0]                 r_mem_din;
    logic [3:0]                  r_mem_wr;
    logic                        r_mem_enable;
    logic [31:0]                 r_m_dout;
    logic [2:0]                  r_m_ready;
    logic                        r_busy;

    assign w_any_req = |i_m_enable;
    assign w_start   = (r_state == S_IDLE) && w_any_req;

    // Round-robin pick: search starts at the master after the last one served
    always_comb begin
        w_cand1  = (r_last_grant == 2'd2) ? 2'd0 : r_last_grant + 2'd1;
        w_cand2  = (w_cand1 == 2'd2) ? 2'd0 : w_cand1 + 2'd1;
        w_winner = r_last_grant;
        if (i_m_enable[w_cand1]) begin
            w_winner = w_cand1;
        end else if (i_m_enable[w_cand2]) begin
            w_winner = w_cand2;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);
    logic [15:0] r_wait_cnt;
    logic [2:0]  r_m_error;

    assign w_expire = (r_wait_cnt + 16'd1) == LP_TIMEOUT;

    // Count WAIT cycles of the current access; cleared when a grant is made
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wait_cnt <= 16'd0;
        end else if (w_start) begin
            r_wait_cnt <= 16'd0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    // Error pulse accompanies the ready pulse only for an expired access
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_m_error <= 3'b000;
        end else begin
            r_m_error <= w_timeout ? (3'b001 << r_grant) : 3'b000;
        end
    end

    assign o_m_error = r_m_error;
`else
    logic w_unused_timeout;

    assign w_expire         = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign o_m_error        = 3'b000;
`endif

    // Next-state logic; memory completion wins over a same-cycle expiry
    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next = S_ACCESS;
            S_ACCESS: w_next = S_WAIT;
            S_WAIT: begin
                if (i_mem_ready) begin
                    w_next = S_RESP;
                end else if (w_expire) begin
                    w_next    = S_RESP;
                    w_timeout = 1'b1;
                end
            end
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Registered outputs derived from the upcoming state, plus grant bookkeeping
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_grant      <= 2'd0;
            r_last_grant <= 2'd2;
            r_mem_addr   <= '0;
            r_mem_din    <= 32'd0;
            r_mem_wr     <= 4'd0;
            r_mem_enable <= 1'b0;
            r_m_dout     <= 32'd0;
            r_m_ready    <= 3'b000;
            r_busy       <= 1'b0;
        end else begin
            r_mem_enable <= w_start;
            r_busy       <= (w_next != S_IDLE);
            r_m_ready    <= (w_next == S_RESP) ? (3'b001 << r_grant) : 3'b000;
            if (w_start) begin
                r_grant    <= w_winner;
                r_mem_addr <= i_m_addr[int'(w_winner)*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
                r_mem_din  <= i_m_din[int'(w_winner)*32 +: 32];
                r_mem_wr   <= i_m_wr[int'(w_winner)*4 +: 4];
            end else begin
                r_mem_wr   <= 4'd0;
            end
            if (r_state == S_WAIT) begin
                if (i_mem_ready) begin
                    r_m_dout <= i_mem_dout;
                end else if (w_timeout) begin
                    r_m_dout <= 32'hDEADBEEF;
                end
            end
            if (r_state == S_RESP) begin
                r_last_grant <= r_grant;
            end
        end
    end

    assign o_mem_addr   = r_mem_addr;
    assign o_mem_din    = r_mem_din;
    assign o_mem_wr     = r_mem_wr;
    assign o_mem_enable = r_mem_enable;
    assign o_m_dout     = r_m_dout;
    assign o_m_ready    = r_m_ready;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter
module tb_memory_arbiter;

    localparam int AW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3*AW-1:0] m_addr;
    logic [95:0]   m_din;
    logic [11:0]   m_wr;
    logic [2:0]    m_enable;
    logic [31:0]   m_dout;
    logic [2:0]    m_ready;
    logic [2:0]    m_error;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [3:0]    mem_wr;
    logic          mem_enable;
    wire  [31:0]   mem_dout;
    logic          mem_ready;
    logic          busy;

    always #5 clk = ~clk;

    memory_arbiter #(.MEM_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m_addr(m_addr), .i_m_din(m_din), .i_m_wr(m_wr), .i_m_enable(m_enable),
        .o_m_dout(m_dout), .o_m_ready(m_ready), .o_m_error(m_error),
        .o_mem_addr(mem_addr), .o_mem_din(mem_din), .o_mem_wr(mem_wr),
        .o_mem_enable(mem_enable), .i_mem_dout(mem_dout), .i_mem_ready(mem_ready),
        .o_busy(busy)
    );

    // Master-side request state
    logic          req_en   [3];
    logic [7:0]    req_addr [3];
    logic [31:0]   req_din  [3];
    logic [3:0]    req_wr   [3];

    always_comb begin
        m_addr   = '0;
        m_din    = '0;
        m_wr     = '0;
        m_enable = '0;
        for (int k = 0; k < 3; k++) begin
            m_addr[k*AW +: AW] = req_addr[k];
            m_din[k*32 +: 32]  = req_din[k];
            m_wr[k*4 +: 4]     = req_wr[k];
            m_enable[k]        = req_en[k];
        end
    end

    // Memory stub: one-cycle ready, optional stall, write echo
    logic [31:0] stub_mem [256];
    logic [31:0] stub_data;
    logic        stub_ready;
    logic        stub_pend;
    logic        stall;
    logic        flush;
    logic        preload;

    function automatic logic [31:0] init_word(input int k);
        logic [7:0] b;
        b = k[7:0];
        if (k == 16) return 32'h12345678;
        if (k == 32) return 32'h11223344;
        return {4{b}};
    endfunction

    always @(posedge clk) begin
        stub_ready <= 1'b0;
        if (preload) begin
            for (int k = 0; k < 256; k++) stub_mem[k] <= init_word(k);
            stub_pend <= 1'b0;
        end else if (mem_enable) begin
            for (int b = 0; b < 4; b++)
                if (mem_wr[b]) stub_mem[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
            stub_data <= (mem_wr != 4'd0) ? mem_din : stub_mem[mem_addr];
            if (stall) stub_pend <= 1'b1;
            else       stub_ready <= 1'b1;
        end else if (flush) begin
            stub_pend <= 1'b0;
        end else if (stub_pend && !stall) begin
            stub_ready <= 1'b1;
            stub_pend  <= 1'b0;
        end
    end

    assign mem_dout  = stub_ready ? stub_data : 32'hzzzzzzzz;
    assign mem_ready = stub_ready;

    // Transaction-level reference model
    logic [31:0] mdl_mem [256];
    int          p;
    int          mdl_win;
    int          mdl_last;
    logic [7:0]  mdl_addr;
    logic [31:0] mdl_din;
    logic [3:0]  mdl_wr;
    logic [31:0] mdl_exp;
    int          mode;
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          rdy_cyc [$];
    int          rdy_who [$];
    logic [31:0] last_dout;

    typedef struct {
        int          m;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [3:0]  wr;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic new_req(input int k);
        req_en[k]   = ($urandom_range(0, 3) != 0);
        req_addr[k] = 8'h40 + 8'($urandom_range(0, 7));
        req_din[k]  = $urandom;
        req_wr[k]   = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    endtask

    // One clock: model decides on the inputs about to be sampled, then outputs are checked
    task automatic step();
        bit found;
        int c;
        if (p == 0 && (req_en[0] || req_en[1] || req_en[2])) begin
            found = 0;
            for (int k = 1; k <= 3; k++) begin
                c = (mdl_last + k) % 3;
                if (!found && req_en[c]) begin
                    mdl_win = c;
                    found   = 1;
                end
            end
            mdl_addr = req_addr[mdl_win];
            mdl_din  = req_din[mdl_win];
            mdl_wr   = req_wr[mdl_win];
            if (mdl_wr == 4'd0) begin
                mdl_exp = mdl_mem[mdl_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mdl_wr[b]) mdl_mem[mdl_addr][b*8 +: 8] = mdl_din[b*8 +: 8];
                mdl_exp = mdl_din;
            end
            p = 1;
        end else if (p != 0) begin
            p++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("m_error", 32'(m_error), 32'd0);
        case (p)
            1: begin
                chk("acc_mem_enable", 32'(mem_enable), 32'd1);
                chk("acc_mem_addr", 32'(mem_addr), 32'(mdl_addr));
                chk("acc_mem_wr", 32'(mem_wr), 32'(mdl_wr));
                chk("acc_mem_din", mem_din, mdl_din);
                chk("acc_m_ready", 32'(m_ready), 32'd0);
                chk("acc_busy", 32'(busy), 32'd1);
            end
            2: begin
                chk("wait_mem_enable", 32'(mem_enable), 32'd0);
                chk("wait_mem_wr", 32'(mem_wr), 32'd0);
                chk("wait_mem_addr", 32'(mem_addr), 32'(mdl_addr));
                chk("wait_m_ready", 32'(m_ready), 32'd0);
                chk("wait_busy", 32'(busy), 32'd1);
            end
            3: begin
                chk("resp_m_ready", 32'(m_ready), 32'd1 << mdl_win);
                chk("resp_m_dout", m_dout, mdl_exp);
                chk("resp_mem_enable", 32'(mem_enable), 32'd0);
                chk("resp_busy", 32'(busy), 32'd1);
            end
            default: begin
                chk("idle_mem_enable", 32'(mem_enable), 32'd0);
                chk("idle_m_ready", 32'(m_ready), 32'd0);
                chk("idle_busy", 32'(busy), 32'd0);
            end
        endcase
        if (p == 3) mdl_last = mdl_win;
        if (p == 4) p = 0;
        for (int k = 0; k < 3; k++) begin
            if (m_ready[k]) begin
                rdy_cyc.push_back(cyc);
                rdy_who.push_back(k);
                last_dout = m_dout;
                if (mode == 0) req_en[k] = 1'b0;
                else if (mode == 2) new_req(k);
            end else if (mode == 2 && !req_en[k]) begin
                if ($urandom_range(0, 1) != 0) new_req(k);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({nm, "_mem_din"}, mem_din, 32'd0);
        chk({nm, "_mem_wr"}, 32'(mem_wr), 32'd0);
        chk({nm, "_mem_enable"}, 32'(mem_enable), 32'd0);
        chk({nm, "_m_dout"}, m_dout, 32'd0);
        chk({nm, "_m_ready"}, 32'(m_ready), 32'd0);
        chk({nm, "_m_error"}, 32'(m_error), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        tbl[0] = '{1, 8'h10, 32'h0,        4'b0000, 32'h12345678};
        tbl[1] = '{0, 8'h20, 32'hAABBCCDD, 4'b0011, 32'hAABBCCDD};
        tbl[2] = '{1, 8'h20, 32'h0,        4'b0000, 32'h1122CCDD};
        tbl[3] = '{2, 8'h00, 32'h5A000000, 4'b1000, 32'h5A000000};
        tbl[4] = '{0, 8'h00, 32'h0,        4'b0000, 32'h5A000000};
        tbl[5] = '{1, 8'hFF, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D};
        tbl[6] = '{0, 8'hFF, 32'h0,        4'b0000, 32'hCAFEF00D};
        tbl[7] = '{2, 8'h10, 32'h0,        4'b0000, 32'h12345678};

        n_checks = 0; n_fail = 0; cyc = 0; p = 0; mdl_last = 2; mode = 0;
        mdl_win = 0; mdl_addr = 0; mdl_din = 0; mdl_wr = 0; mdl_exp = 0; last_dout = 0;
        rst = 1'b0; preload = 1'b1; stall = 1'b0; flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_en[k] = 1'b0; req_addr[k] = 8'h0; req_din[k] = 32'h0; req_wr[k] = 4'h0;
        end
        for (int k = 0; k < 256; k++) mdl_mem[k] = init_word(k);

        // Reset state
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        chk_all_zero("reset");
        rst = 1'b1;
        run(10);

        // Single transactions from the vector table
        foreach (tbl[i]) begin
            rdy_who.delete(); rdy_cyc.delete();
            req_addr[tbl[i].m] = tbl[i].addr;
            req_din[tbl[i].m]  = tbl[i].din;
            req_wr[tbl[i].m]   = tbl[i].wr;
            req_en[tbl[i].m]   = 1'b1;
            run(4);
            chk($sformatf("vec%0d_count", i), 32'(rdy_who.size()), 32'd1);
            if (rdy_who.size() == 1) begin
                chk($sformatf("vec%0d_who", i), 32'(rdy_who[0]), 32'(tbl[i].m));
                chk($sformatf("vec%0d_dout", i), last_dout, tbl[i].exp);
            end
        end

        // All three masters requesting continuously
        rdy_who.delete(); rdy_cyc.delete();
        req_addr[0] = 8'h10; req_addr[1] = 8'h20; req_addr[2] = 8'hFF;
        for (int k = 0; k < 3; k++) begin req_wr[k] = 4'd0; req_en[k] = 1'b1; end
        mode = 1;
        run(24);
        chk("rr_count", 32'(rdy_who.size()), 32'd6);
        for (int j = 0; j < 6 && j < rdy_who.size(); j++) begin
            chk($sformatf("rr_order%0d", j), 32'(rdy_who[j]), 32'(j % 3));
            if (j > 0) chk($sformatf("rr_spacing%0d", j), 32'(rdy_cyc[j] - rdy_cyc[j-1]), 32'd4);
        end
        for (int k = 0; k < 3; k++) req_en[k] = 1'b0;
        mode = 0;

        // Master drops enable during the access; the pulse still arrives
        rdy_who.delete(); rdy_cyc.delete();
        req_addr[1] = 8'h20; req_en[1] = 1'b1;
        step();
        req_en[1] = 1'b0;
        run(3);
        chk("drop_count", 32'(rdy_who.size()), 32'd1);

        // Asynchronous reset while master 2 waits on a stalled memory
        req_addr[2] = 8'h10; req_wr[2] = 4'd0; req_en[2] = 1'b1; stall = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_acc_enable", 32'(mem_enable), 32'd1);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("rst_wait_busy", 32'(busy), 32'd1);
        chk("rst_wait_ready", 32'(m_ready), 32'd0);
        #2 rst = 1'b0;
        #1 chk_all_zero("async_rst");
        req_addr[0] = 8'h20; req_wr[0] = 4'd0; req_en[0] = 1'b1;
        stall = 1'b0; flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0; rst = 1'b1; p = 0; mdl_last = 2;
        rdy_who.delete(); rdy_cyc.delete();
        run(8);
        chk("post_rst_count", 32'(rdy_who.size()), 32'd2);
        if (rdy_who.size() == 2) begin
            chk("post_rst_first", 32'(rdy_who[0]), 32'd0);
            chk("post_rst_second", 32'(rdy_who[1]), 32'd2);
        end

        // After reset with only master 2 requesting, it is granted first
        rst = 1'b0;
        #3 rst = 1'b1;
        p = 0; mdl_last = 2;
        rdy_who.delete(); rdy_cyc.delete();
        req_addr[2] = 8'h00; req_en[2] = 1'b1;
        run(4);
        chk("solo2_count", 32'(rdy_who.size()), 32'd1);
        if (rdy_who.size() == 1) chk("solo2_who", 32'(rdy_who[0]), 32'd2);

        // Randomised traffic against the model
        mode = 2;
        run(600);
        mode = 0;
        run(16);
        for (int k = 0; k < 3; k++) req_en[k] = 1'b0;
        run(4);

`ifdef ARB_TIMEOUT_EN
        // Stalled memory: timeout response after TO wait cycles
        stall = 1'b1;
        req_addr[0] = 8'h10; req_wr[0] = 4'd0; req_en[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("to_enable", 32'(mem_enable), 32'd1);
        for (int c = 0; c < TO; c++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("to_wait%0d_ready", c), 32'(m_ready), 32'd0);
        end
        @(posedge clk); @(negedge clk);
        req_en[0] = 1'b0;
        chk("to_ready", 32'(m_ready), 32'd1);
        chk("to_error", 32'(m_error), 32'd1);
        chk("to_dout", m_dout, 32'hDEADBEEF);
        @(posedge clk); @(negedge clk);
        chk("to_after_ready", 32'(m_ready), 32'd0);
        chk("to_after_error", 32'(m_error), 32'd0);
        chk("to_after_busy", 32'(busy), 32'd0);
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0; stall = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
